ram_lsu: RTL and testbench

Parametrised data-memory block with a request/response handshake, byte/half/word access sizes and configurable read wait states. It is the next generation of the core's flat word RAM and its separate byte-mask logic: lane placement, sign/zero extension and range checking are done inside the block. It sits between the load/store path of the core (or a future multi-cycle core) and the data storage, and it stalls the requester through `ready_o`.

---
 rtl/ram_lsu.sv | 162 ++++++++++++++++
 tb/tb_ram_lsu.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ram_lsu.sv
// ram_lsu: word RAM with request/response handshake, byte/half/word lanes and LATENCY read wait states.
// Define RAM_LSU_MISALIGN_ERR_EN to reject misaligned half/word accesses instead of aligning them down.
module ram_lsu #(
   parameter int unsigned DEPTH   = 512,
   parameter int unsigned LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [1:0]  size_i,
   input  logic        sign_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        ready_o,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic        err_o
);

   localparam int unsigned AW       = $clog2(DEPTH);
   localparam logic [2:0]  CNT_INIT = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

   state_e        state_q;
   logic [2:0]    cnt_q;
   logic          ready_q;
   logic          rvalid_q;
   logic [31:0]   rdata_q;
   logic          err_q;
   logic          we_q;
   logic [1:0]    size_q;
   logic          sign_q;
   logic [1:0]    off_q;
   logic          rej_q;
   logic [31:0]   hold_q;
   logic [31:0]   mem [DEPTH];

   logic          accept;
   logic [AW-1:0] widx;
   logic          range_err;
   logic          size_err;
   logic          align_err;
   logic          rej_d;
   logic [1:0]    off_d;
   logic [3:0]    be;
   logic [31:0]   wlane;
   logic [31:0]   shifted;
   logic [31:0]   ext_d;

   always_comb begin
      // reset gate keeps a request during reset from touching memory
      accept    = req_i & ready_q & reset;
      widx      = addr_i[AW+1:2];
      range_err = {2'b00, addr_i[31:2]} >= DEPTH;
      size_err  = (size_i == 2'b11);
      off_d     = addr_i[1:0];
      align_err = 1'b0;
`ifdef RAM_LSU_MISALIGN_ERR_EN
      align_err = (size_i == 2'b01 && addr_i[0]) ||
                  (size_i == 2'b10 && addr_i[1:0] != 2'b00);
`else
      if (size_i == 2'b01) begin
         off_d = {addr_i[1], 1'b0};
      end else if (size_i == 2'b10) begin
         off_d = 2'b00;
      end
`endif
      rej_d = range_err | size_err | align_err;

      case (size_i)
         2'b00: begin
            be    = 4'b0001 << off_d;
            wlane = {4{wdata_i[7:0]}};
         end
         2'b01: begin
            be    = off_d[1] ? 4'b1100 : 4'b0011;
            wlane = {2{wdata_i[15:0]}};
         end
         default: begin
            be    = 4'b1111;
            wlane = wdata_i;
         end
      endcase

      shifted = hold_q >> {off_q, 3'b000};
      case (size_q)
         2'b00:   ext_d = {{24{sign_q & shifted[7]}}, shifted[7:0]};
         2'b01:   ext_d = {{16{sign_q & shifted[15]}}, shifted[15:0]};
         default: ext_d = hold_q;
      endcase
   end

   // Storage is deliberately outside the reset domain: contents survive reset.
   always_ff @(posedge clk) begin
      if (accept && !rej_d) begin
         if (we_i) begin
            for (int unsigned b = 0; b < 4; b++) begin
               if (be[b]) mem[widx][8*b +: 8] <= wlane[8*b +: 8];
            end
         end else begin
            hold_q <= mem[widx];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         ready_q  <= 1'b1;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         we_q     <= 1'b0;
         size_q   <= '0;
         sign_q   <= 1'b0;
         off_q    <= '0;
         rej_q    <= 1'b0;
      end else begin
         rvalid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  we_q    <= we_i;
                  size_q  <= size_i;
                  sign_q  <= sign_i;
                  off_q   <= off_d;
                  rej_q   <= rej_d;
                  ready_q <= 1'b0;
                  if (LATENCY == 0) begin
                     state_q <= RESP;
                  end else begin
                     state_q <= BUSY;
                     cnt_q   <= CNT_INIT;
                  end
               end
            end
            BUSY: begin
               if (cnt_q == '0) state_q <= RESP;
               else             cnt_q   <= cnt_q - 3'd1;
            end
            RESP: begin
               // outputs are registered here, so the strobe lands one edge after RESP
               state_q  <= IDLE;
               ready_q  <= 1'b1;
               rvalid_q <= 1'b1;
               err_q    <= rej_q;
               rdata_q  <= (rej_q | we_q) ? '0 : ext_d;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ready_o  = ready_q;
   assign rvalid_o = rvalid_q;
   assign rdata_o  = rdata_q;
   assign err_o    = err_q;

endmodule

// File: tb/tb_ram_lsu.sv
// Scoreboard bench for ram_lsu: LATENCY=1 instance for lane/extension/error cases, LATENCY=3 for reset abort.
`timescale 1ns/1ps
module tb_ram_lsu;

   localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, X = 2'b11;

   logic        clk = 1'b0;
   logic        rst1, rst3, req1, req3, we, sign;
   logic [1:0]  size;
   logic [31:0] addr, wdata;
   logic        rdy1, rv1, err1, rdy3, rv3, err3;
   logic [31:0] rd1, rd3;

   int cyc    = 0;
   int n_pass = 0;
   int n_chk  = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t q1[$];
   exp_t q3[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ram_lsu #(.DEPTH(512), .LATENCY(1)) u_l1 (
      .clk(clk), .reset(rst1), .req_i(req1), .we_i(we), .size_i(size), .sign_i(sign),
      .addr_i(addr), .wdata_i(wdata), .ready_o(rdy1), .rvalid_o(rv1), .rdata_o(rd1), .err_o(err1)
   );

   ram_lsu #(.DEPTH(512), .LATENCY(3)) u_l3 (
      .clk(clk), .reset(rst3), .req_i(req3), .we_i(we), .size_i(size), .sign_i(sign),
      .addr_i(addr), .wdata_i(wdata), .ready_o(rdy3), .rvalid_o(rv3), .rdata_o(rd3), .err_o(err3)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   // Monitor: pops the oldest expectation whenever a response strobe is seen.
   always @(negedge clk) begin
      exp_t e;
      if (rv1 === 1'b1) begin
         if (q1.size() == 0) begin
            n_chk++;
            $display("FAIL l1 unexpected rvalid: got 1 expected 0");
         end else begin
            e = q1.pop_front();
            check("l1 rdata", rd1, e.rdata);
            check("l1 err", 32'(err1), 32'(e.err));
            check("l1 resp cycle", 32'(cyc), 32'(e.cyc));
         end
      end
      if (rv3 === 1'b1) begin
         if (q3.size() == 0) begin
            n_chk++;
            $display("FAIL l3 unexpected rvalid: got 1 expected 0");
         end else begin
            e = q3.pop_front();
            check("l3 rdata", rd3, e.rdata);
            check("l3 err", 32'(err3), 32'(e.err));
            check("l3 resp cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   // Returns just after the accept edge; fields are scrambled so capture is exercised.
   task automatic issue(input int inst, input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input logic exp_err, input bit track);
      int   n = 0;
      exp_t e;
      @(negedge clk);
      while (((inst == 1) ? rdy1 : rdy3) !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) begin
         n_chk++;
         $display("FAIL ready timeout inst %0d: got 0 expected 1", inst);
         return;
      end
      we = w; size = sz; sign = sg; addr = a; wdata = d;
      if (inst == 1) req1 = 1'b1;
      else           req3 = 1'b1;
      e.rdata = exp_rd;
      e.err   = exp_err;
      e.cyc   = cyc + 2 + ((inst == 1) ? 1 : 3);
      if (track) begin
         if (inst == 1) q1.push_back(e);
         else           q3.push_back(e);
      end
      @(posedge clk);
      #1;
      req1 = 1'b0; req3 = 1'b0;
      we = ~w; size = 2'b00; sign = ~sg; addr = 32'hFFFF_FFFC; wdata = ~d;
   endtask

   initial begin
      int n;
      rst1 = 1'b0; rst3 = 1'b0; req1 = 1'b0; req3 = 1'b0;
      we = 1'b0; size = 2'b00; sign = 1'b0; addr = '0; wdata = '0;
      repeat (2) @(negedge clk);
      check("l1 reset ready", 32'(rdy1), 32'd1);
      check("l1 reset rvalid", 32'(rv1), 32'd0);
      check("l1 reset rdata", rd1, 32'd0);
      check("l1 reset err", 32'(err1), 32'd0);
      check("l3 reset ready", 32'(rdy3), 32'd1);
      check("l3 reset rvalid", 32'(rv3), 32'd0);
      rst1 = 1'b1; rst3 = 1'b1;

      // word store/load, byte lanes with extension
      issue(1, 1, W, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 1);
      issue(1, 0, W, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 1);
      issue(1, 1, W, 0, 32'h10, 32'h0, 32'h0, 0, 1);
      issue(1, 1, B, 0, 32'h13, 32'h12345680, 32'h0, 0, 1);
      issue(1, 0, B, 1, 32'h13, 32'h0, 32'hFFFFFF80, 0, 1);
      issue(1, 0, B, 0, 32'h13, 32'h0, 32'h00000080, 0, 1);
      issue(1, 0, W, 1, 32'h10, 32'h0, 32'h80000000, 0, 1);
      issue(1, 0, B, 1, 32'h12, 32'h0, 32'h00000000, 0, 1);
      // half lanes
      issue(1, 1, W, 0, 32'h14, 32'h0, 32'h0, 0, 1);
      issue(1, 1, H, 0, 32'h16, 32'hAAAABEEF, 32'h0, 0, 1);
      issue(1, 0, H, 1, 32'h16, 32'h0, 32'hFFFFBEEF, 0, 1);
      issue(1, 0, W, 0, 32'h14, 32'h0, 32'hBEEF0000, 0, 1);
      issue(1, 0, H, 1, 32'h14, 32'h0, 32'h00000000, 0, 1);
      // range and illegal-size errors; rejected store leaves memory alone
      issue(1, 0, W, 0, 32'h800, 32'h0, 32'h0, 1, 1);
      issue(1, 0, X, 0, 32'h10, 32'h0, 32'h0, 1, 1);
      issue(1, 1, X, 0, 32'h10, 32'hFFFFFFFF, 32'h0, 1, 1);
      issue(1, 1, W, 0, 32'h800, 32'hFFFFFFFF, 32'h0, 1, 1);
      issue(1, 0, W, 0, 32'h10, 32'h0, 32'h80000000, 0, 1);
      // last word
      issue(1, 1, W, 0, 32'h7FC, 32'h0BADF00D, 32'h0, 0, 1);
      issue(1, 0, W, 0, 32'h7FC, 32'h0, 32'h0BADF00D, 0, 1);
      // misalignment
      issue(1, 1, W, 0, 32'h20, 32'h11111111, 32'h0, 0, 1);
      issue(1, 1, W, 0, 32'h24, 32'h22222222, 32'h0, 0, 1);
`ifdef RAM_LSU_MISALIGN_ERR_EN
      issue(1, 1, W, 0, 32'h22, 32'hCAFEF00D, 32'h0, 1, 1);
      issue(1, 0, W, 0, 32'h20, 32'h0, 32'h11111111, 0, 1);
      issue(1, 0, H, 0, 32'h17, 32'h0, 32'h0, 1, 1);
`else
      issue(1, 1, W, 0, 32'h22, 32'hCAFEF00D, 32'h0, 0, 1);
      issue(1, 0, W, 0, 32'h20, 32'h0, 32'hCAFEF00D, 0, 1);
      issue(1, 0, H, 0, 32'h17, 32'h0, 32'h0000BEEF, 0, 1);
`endif
      issue(1, 0, W, 0, 32'h24, 32'h0, 32'h22222222, 0, 1);

      // LATENCY=3: reset during BUSY drops the response but keeps the store
      issue(3, 1, W, 0, 32'h40, 32'h12345678, 32'h0, 0, 1);
      issue(3, 1, W, 0, 32'h44, 32'hA5A55A5A, 32'h0, 0, 0);
      @(negedge clk);
      rst3 = 1'b0;
      #1;
      check("l3 ready in reset", 32'(rdy3), 32'd1);
      check("l3 rvalid in reset", 32'(rv3), 32'd0);
      repeat (3) begin
         @(negedge clk);
         check("l3 rvalid held in reset", 32'(rv3), 32'd0);
      end
      rst3 = 1'b1;
      repeat (6) @(negedge clk);
      issue(3, 0, W, 0, 32'h44, 32'h0, 32'hA5A55A5A, 0, 1);
      issue(3, 0, W, 0, 32'h40, 32'h0, 32'h12345678, 0, 1);
      issue(3, 0, B, 1, 32'h47, 32'h0, 32'hFFFFFFA5, 0, 1);

      n = 0;
      while ((q1.size() != 0 || q3.size() != 0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("pending responses", 32'(q1.size() + q3.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
